ex_mem_stage: RTL and testbench
===============================

Name: ex_mem_stage

Overview:
- Pipeline register and branch-resolution stage directly downstream of the ALU.
- Captures the execute-stage ALU result, EQ flag, store data, destination register and control bits, and presents them to the memory/writeback stage.
- Resolves BEQ/BNE/JAL from the ALU EQ flag and drives the PC redirect and front-end flush.
- Supports stall (hold), flush (bubble insertion) and a saturating taken-branch counter for performance debug.

Parameters:
- WIDTH, 32, datapath width (ALU result, PC, immediate, store data)
- REG_AW, 5, register index width
- CNT_WIDTH, 16, width of taken-branch counter

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold M-stage contents; E-stage instruction does not advance
- flush  in  1  load a bubble into M stage
- valid_e  in  1  E-stage instruction valid
- ALUout_e  in  WIDTH  ALU result
- EQ_e  in  1  ALU zero flag (ALUout_e == 0)
- regOp2_e  in  WIDTH  store data (rs2 value)
- PC_e  in  WIDTH  PC of E-stage instruction
- ImmOp_e  in  WIDTH  sign-extended immediate
- rd_e  in  REG_AW  destination register
- RegWrite_e  in  1  register write enable
- MemWrite_e  in  1  data-memory write enable
- ResultSrc_e  in  2  writeback select (00 ALU, 01 mem, 10 PC+4)
- Branch_e  in  2  00 none, 01 BEQ, 10 BNE, 11 JAL
- valid_m  out  1  M-stage valid
- ALUout_m  out  WIDTH  registered ALU result
- WriteData_m  out  WIDTH  registered store data
- PCplus4_m  out  WIDTH  registered PC_e + 4
- rd_m  out  REG_AW  registered destination
- RegWrite_m  out  1  registered, gated write enable
- MemWrite_m  out  1  registered, gated write enable
- ResultSrc_m  out  2  registered writeback select
- PCsrc  out  1  combinational redirect request
- PCtarget  out  WIDTH  combinational branch target
- flush_fd  out  1  combinational flush request to fetch/decode (= PCsrc)
- br_taken_cnt  out  CNT_WIDTH  taken-branch counter

Behaviour:
- Redirect, combinational, E stage:
  - taken = valid_e & ((Branch_e==01 & EQ_e) | (Branch_e==10 & ~EQ_e) | (Branch_e==11)).
  - PCsrc = taken & ~stall; flush_fd = PCsrc.
  - PCtarget = PC_e + ImmOp_e, modulo 2^WIDTH (wraps, no overflow flag); driven regardless of PCsrc.
- Register update, rising clk, priority rst > flush > stall > load:
  - rst: all M-stage outputs 0, br_taken_cnt 0.
  - flush: valid_m, RegWrite_m, MemWrite_m, rd_m, ResultSrc_m, ALUout_m, WriteData_m, PCplus4_m all 0. flush with stall together: flush wins.
  - stall (no flush): every M-stage register holds its value.
  - load:
    - valid_m <= valid_e
    - ALUout_m <= ALUout_e; WriteData_m <= regOp2_e
    - PCplus4_m <= PC_e + 4 (mod 2^WIDTH); rd_m <= rd_e; ResultSrc_m <= ResultSrc_e
    - RegWrite_m <= RegWrite_e & valid_e & (rd_e != 0)
    - MemWrite_m <= MemWrite_e & valid_e
- Latency: exactly 1 cycle E to M when not stalled.
- Invalid E instruction (valid_e=0) loads as a bubble: enables 0, data fields still captured.
- x0 writes never propagate: RegWrite_m is 0 whenever rd_e == 0.
- br_taken_cnt:
  - Increments by 1 on each edge where PCsrc=1 and rst=0.
  - Saturates at all-ones.
  - Unaffected by flush; a cycle with flush and PCsrc both high still counts.
- Reset mid-stall or mid-flush: reset wins. All outputs are 0 on the cycle after the edge, regardless of stall/flush/valid_e.
- No X on outputs after the first reset edge. PCsrc/PCtarget depend only on current inputs.

Test Plan:
- Reset: rst=1 for 2 cycles with valid_e=1, RegWrite_e=1, stall=1 -> all M outputs and br_taken_cnt = 0 after the edge.
- Normal capture: ALUout_e=0x0000_0010, regOp2_e=0xDEAD_BEEF, PC_e=0x0000_0100, rd_e=5, RegWrite_e=1, valid_e=1 -> next cycle ALUout_m=0x10, WriteData_m=0xDEADBEEF, PCplus4_m=0x104, rd_m=5, RegWrite_m=1, valid_m=1.
- Branch resolution with PC_e=0x100, ImmOp_e=0xFFFF_FFF8:
  - BEQ with EQ_e=1 -> PCsrc=1, flush_fd=1, PCtarget=0x0F8, counter 0->1.
  - BNE with EQ_e=1 -> PCsrc=0.
  - JAL -> PCsrc=1.
  - PC_e=0xFFFF_FFFC, ImmOp_e=8 -> PCtarget=0x4 (wrap).
- Stall/flush interaction:
  - stall=1 for 3 cycles with changing E inputs -> M outputs frozen; BEQ taken while stalled -> PCsrc=0, counter unchanged.
  - stall=1 and flush=1 together -> valid_m=0, RegWrite_m=0, MemWrite_m=0.
- x0 and bubble gating:
  - rd_e=0, RegWrite_e=1, valid_e=1 -> RegWrite_m=0.
  - valid_e=0, MemWrite_e=1 -> MemWrite_m=0, valid_m=0.
- Counter saturation (CNT_WIDTH=4): 20 consecutive taken JALs, stall=0 -> br_taken_cnt reaches 15 and stays 15; then rst -> 0.

Source files
------------

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with branch resolution.
// Resolves BEQ/BNE/JAL from the ALU EQ flag and counts taken branches.
module ex_mem_stage #(
  parameter int WIDTH     = 32,
  parameter int REG_AW    = 5,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 valid_e,
  input  logic [WIDTH-1:0]     ALUout_e,
  input  logic                 EQ_e,
  input  logic [WIDTH-1:0]     regOp2_e,
  input  logic [WIDTH-1:0]     PC_e,
  input  logic [WIDTH-1:0]     ImmOp_e,
  input  logic [REG_AW-1:0]    rd_e,
  input  logic                 RegWrite_e,
  input  logic                 MemWrite_e,
  input  logic [1:0]           ResultSrc_e,
  input  logic [1:0]           Branch_e,
  output logic                 valid_m,
  output logic [WIDTH-1:0]     ALUout_m,
  output logic [WIDTH-1:0]     WriteData_m,
  output logic [WIDTH-1:0]     PCplus4_m,
  output logic [REG_AW-1:0]    rd_m,
  output logic                 RegWrite_m,
  output logic                 MemWrite_m,
  output logic [1:0]           ResultSrc_m,
  output logic                 PCsrc,
  output logic [WIDTH-1:0]     PCtarget,
  output logic                 flush_fd,
  output logic [CNT_WIDTH-1:0] br_taken_cnt
);

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_BEQ  = 2'b01,
    BR_BNE  = 2'b10,
    BR_JAL  = 2'b11
  } branch_e;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic taken;

  assign taken = valid_e & ((Branch_e == BR_BEQ &  EQ_e) |
                            (Branch_e == BR_BNE & ~EQ_e) |
                            (Branch_e == BR_JAL));

  // A stalled branch must not redirect: it will be re-resolved when it advances.
  assign PCsrc    = taken & ~stall;
  assign flush_fd = PCsrc;
  assign PCtarget = PC_e + ImmOp_e;

  // NOTE: all state here is sequential, so every assignment is non-blocking;
  // blocking assignments would let later statements see same-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_m      <= 1'b0;
      ALUout_m     <= '0;
      WriteData_m  <= '0;
      PCplus4_m    <= '0;
      rd_m         <= '0;
      RegWrite_m   <= 1'b0;
      MemWrite_m   <= 1'b0;
      ResultSrc_m  <= '0;
      br_taken_cnt <= '0;
    end else begin
      if (flush) begin
        valid_m     <= 1'b0;
        ALUout_m    <= '0;
        WriteData_m <= '0;
        PCplus4_m   <= '0;
        rd_m        <= '0;
        RegWrite_m  <= 1'b0;
        MemWrite_m  <= 1'b0;
        ResultSrc_m <= '0;
      end else if (!stall) begin
        // Bubbles still capture data fields; only the enables are gated.
        valid_m     <= valid_e;
        ALUout_m    <= ALUout_e;
        WriteData_m <= regOp2_e;
        PCplus4_m   <= PC_e + WIDTH'(4);
        rd_m        <= rd_e;
        RegWrite_m  <= RegWrite_e & valid_e & (rd_e != '0);
        MemWrite_m  <= MemWrite_e & valid_e;
        ResultSrc_m <= ResultSrc_e;
      end

      // Counting is independent of flush; it saturates rather than wraps.
      if (PCsrc && br_taken_cnt != CNT_MAX)
        br_taken_cnt <= br_taken_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed steps plus randomized traffic
// compared against a cycle-level behavioural model of the stage.
module tb_ex_mem_stage;

  localparam int W  = 32;
  localparam int AW = 5;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, stall, flush, valid_e, EQ_e;
  logic [W-1:0]  ALUout_e, regOp2_e, PC_e, ImmOp_e;
  logic [AW-1:0] rd_e;
  logic          RegWrite_e, MemWrite_e;
  logic [1:0]    ResultSrc_e, Branch_e;

  logic          valid_m, RegWrite_m, MemWrite_m, PCsrc, flush_fd;
  logic [W-1:0]  ALUout_m, WriteData_m, PCplus4_m, PCtarget;
  logic [AW-1:0] rd_m;
  logic [1:0]    ResultSrc_m;
  logic [CW-1:0] br_taken_cnt;

  ex_mem_stage #(.WIDTH(W), .REG_AW(AW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_e(valid_e),
    .ALUout_e(ALUout_e), .EQ_e(EQ_e), .regOp2_e(regOp2_e), .PC_e(PC_e),
    .ImmOp_e(ImmOp_e), .rd_e(rd_e), .RegWrite_e(RegWrite_e),
    .MemWrite_e(MemWrite_e), .ResultSrc_e(ResultSrc_e), .Branch_e(Branch_e),
    .valid_m(valid_m), .ALUout_m(ALUout_m), .WriteData_m(WriteData_m),
    .PCplus4_m(PCplus4_m), .rd_m(rd_m), .RegWrite_m(RegWrite_m),
    .MemWrite_m(MemWrite_m), .ResultSrc_m(ResultSrc_m), .PCsrc(PCsrc),
    .PCtarget(PCtarget), .flush_fd(flush_fd), .br_taken_cnt(br_taken_cnt)
  );

  // Expected M-stage contents as seen by the memory/writeback stage.
  typedef struct packed {
    logic          v;
    logic [W-1:0]  alu;
    logic [W-1:0]  wd;
    logic [W-1:0]  pc4;
    logic [AW-1:0] rd;
    logic          rw;
    logic          mw;
    logic [1:0]    rs;
  } mstate_t;

  mstate_t exp_m;
  int      exp_cnt;
  int      errors = 0;
  int      checks = 0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic model_taken();
    case (Branch_e)
      2'b01:   return valid_e && EQ_e;
      2'b10:   return valid_e && !EQ_e;
      2'b11:   return valid_e;
      default: return 1'b0;
    endcase
  endfunction

  task automatic set_idle();
    rst = 0; stall = 0; flush = 0; valid_e = 0; EQ_e = 0;
    ALUout_e = '0; regOp2_e = '0; PC_e = '0; ImmOp_e = '0; rd_e = '0;
    RegWrite_e = 0; MemWrite_e = 0; ResultSrc_e = '0; Branch_e = '0;
  endtask

  // Inputs are applied at the falling edge; comb outputs are checked before
  // the rising edge, registered outputs at the following falling edge.
  task automatic step();
    logic redirect;
    #1;
    redirect = model_taken() && !stall;
    check("PCsrc", PCsrc, redirect);
    check("flush_fd", flush_fd, redirect);
    check("PCtarget", PCtarget, PC_e + ImmOp_e);

    if (rst) begin
      exp_m   = '0;
      exp_cnt = 0;
    end else begin
      if (redirect && exp_cnt < CNT_MAX) exp_cnt = exp_cnt + 1;
      if (flush) exp_m = '0;
      else if (!stall) begin
        exp_m.v   = valid_e;
        exp_m.alu = ALUout_e;
        exp_m.wd  = regOp2_e;
        exp_m.pc4 = PC_e + 32'd4;
        exp_m.rd  = rd_e;
        exp_m.rw  = RegWrite_e && valid_e && (rd_e != 0);
        exp_m.mw  = MemWrite_e && valid_e;
        exp_m.rs  = ResultSrc_e;
      end
    end

    @(posedge clk);
    @(negedge clk);
    check("valid_m", valid_m, exp_m.v);
    check("ALUout_m", ALUout_m, exp_m.alu);
    check("WriteData_m", WriteData_m, exp_m.wd);
    check("PCplus4_m", PCplus4_m, exp_m.pc4);
    check("rd_m", rd_m, exp_m.rd);
    check("RegWrite_m", RegWrite_m, exp_m.rw);
    check("MemWrite_m", MemWrite_m, exp_m.mw);
    check("ResultSrc_m", ResultSrc_m, exp_m.rs);
    check("br_taken_cnt", br_taken_cnt, exp_cnt);
  endtask

  task automatic randomize_e();
    valid_e     = ($urandom_range(3) != 0);
    ALUout_e    = ($urandom_range(3) == 0) ? '0 : $urandom;
    EQ_e        = (ALUout_e == 0);
    regOp2_e    = $urandom;
    PC_e        = $urandom & 32'hFFFF_FFFC;
    ImmOp_e     = $urandom;
    rd_e        = AW'($urandom);
    RegWrite_e  = $urandom_range(1);
    MemWrite_e  = $urandom_range(1);
    ResultSrc_e = 2'($urandom_range(2));
    Branch_e    = 2'($urandom);
  endtask

  initial begin
    exp_m   = '0;
    exp_cnt = 0;
    set_idle();
    @(negedge clk);

    // Reset dominates an active, stalled E-stage instruction.
    rst = 1; valid_e = 1; RegWrite_e = 1; stall = 1; rd_e = 5'd3;
    step();
    step();
    check("reset_valid_m", valid_m, 0);
    check("reset_cnt", br_taken_cnt, 0);

    // Normal capture.
    set_idle();
    ALUout_e = 32'h0000_0010; regOp2_e = 32'hDEAD_BEEF; PC_e = 32'h0000_0100;
    rd_e = 5'd5; RegWrite_e = 1; valid_e = 1;
    step();
    check("cap_alu", ALUout_m, 32'h10);
    check("cap_wd", WriteData_m, 32'hDEAD_BEEF);
    check("cap_pc4", PCplus4_m, 32'h104);
    check("cap_rw", RegWrite_m, 1);

    // Branch resolution with a negative offset.
    set_idle();
    valid_e = 1; PC_e = 32'h100; ImmOp_e = 32'hFFFF_FFF8;
    Branch_e = 2'b01; EQ_e = 1;
    #1;
    check("beq_pcsrc", PCsrc, 1);
    check("beq_target", PCtarget, 32'h0F8);
    step();
    check("beq_cnt", br_taken_cnt, 1);
    Branch_e = 2'b10; EQ_e = 1;
    #1;
    check("bne_eq_pcsrc", PCsrc, 0);
    step();
    Branch_e = 2'b11; EQ_e = 0;
    #1;
    check("jal_pcsrc", PCsrc, 1);
    step();
    PC_e = 32'hFFFF_FFFC; ImmOp_e = 32'd8; Branch_e = 2'b00;
    #1;
    check("wrap_target", PCtarget, 32'h4);
    step();
    check("wrap_pc4", PCplus4_m, 32'h0);

    // Stall for three cycles with changing inputs, including a taken BEQ.
    for (int i = 0; i < 3; i++) begin
      randomize_e();
      stall = 1; valid_e = 1;
      if (i == 1) begin Branch_e = 2'b01; EQ_e = 1; end
      step();
    end
    check("stall_pc4_frozen", PCplus4_m, 32'h0);
    check("stall_cnt", br_taken_cnt, 2);

    // Flush beats stall.
    randomize_e();
    valid_e = 1; RegWrite_e = 1; MemWrite_e = 1; rd_e = 5'd7;
    stall = 1; flush = 1;
    step();
    check("flush_valid_m", valid_m, 0);
    check("flush_mw", MemWrite_m, 0);

    // x0 destination and bubble gating.
    set_idle();
    valid_e = 1; RegWrite_e = 1; rd_e = 5'd0; ALUout_e = 32'h55;
    step();
    check("x0_rw", RegWrite_m, 0);
    valid_e = 0; MemWrite_e = 1; rd_e = 5'd9; RegWrite_e = 1; ALUout_e = 32'h77;
    step();
    check("bubble_mw", MemWrite_m, 0);
    check("bubble_alu", ALUout_m, 32'h77);

    // Randomized traffic with occasional stall, flush and reset.
    for (int i = 0; i < 300; i++) begin
      randomize_e();
      stall = ($urandom_range(3) == 0);
      flush = ($urandom_range(9) == 0);
      rst   = ($urandom_range(39) == 0);
      step();
    end

    // Counter saturation, then reset clears it.
    set_idle();
    rst = 1;
    step();
    rst = 0; valid_e = 1; Branch_e = 2'b11; PC_e = 32'h200; ImmOp_e = 32'h40;
    for (int i = 0; i < 20; i++) step();
    check("sat_cnt", br_taken_cnt, CNT_MAX);
    rst = 1;
    step();
    check("sat_reset_cnt", br_taken_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
